// File: rtl/reduce_window.sv
// Windowed flag reducer: reduces each accepted sample with OR/AND/XOR/NOR and
// folds WINDOW samples into one registered result with a saturating hit counter.
module reduce_window #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             o,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] WIN_C = CW'(WINDOW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] M_AND = 2'b01;
  localparam logic [1:0] M_XOR = 2'b10;
  localparam logic [1:0] M_NOR = 2'b11;

  logic [1:0]    state;
  logic [1:0]    mode_q;
  logic [CW-1:0] cnt;
  logic          acc;

  logic [1:0]    eff_mode;
  logic          r;
  logic          acc_nxt;
  logic [CW-1:0] cnt_nxt;
  logic          res;
  logic          fin;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign busy      = (state == ACC);

  // The first sample of a window uses the live mode; the rest use the latched one.
  always_comb begin
    eff_mode = (state == IDLE) ? mode : mode_q;
    case (eff_mode)
      M_AND:   r = &in_data;
      M_XOR:   r = ^in_data;
      default: r = |in_data;
    endcase
    if (state == IDLE) begin
      acc_nxt = r;
      cnt_nxt = CW'(1);
    end else begin
      case (mode_q)
        M_AND:   acc_nxt = acc & r;
        M_XOR:   acc_nxt = acc ^ r;
        default: acc_nxt = acc | r;
      endcase
      cnt_nxt = cnt + CW'(1);
    end
    res = (eff_mode == M_NOR) ? ~acc_nxt : acc_nxt;
    fin = (cnt_nxt == WIN_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mode_q  <= 2'b00;
      cnt     <= '0;
      acc     <= 1'b0;
      o       <= 1'b0;
      hit_cnt <= '0;
    end else if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= 1'b0;
      o       <= 1'b0;
      hit_cnt <= '0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (in_valid) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (state == IDLE) mode_q <= mode;
            if (fin) begin
              state <= DONE;
              o     <= res;
              if (res && (hit_cnt != {CNT_W{1'b1}})) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reduce_window.sv
// Directed bench for reduce_window: default build, a 2-bit hit counter build
// and a WINDOW=1 build share one stimulus bus.
module tb_reduce_window;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;

  logic       rdy0, o0, ov0, busy0;
  logic [7:0] hit0;
  logic       rdy1, o1, ov1, busy1;
  logic [1:0] hit1;
  logic       rdy2, o2, ov2, busy2;
  logic [7:0] hit2;

  int checks = 0;
  int failures = 0;
  int exp_hit = 0;

  always #5 clk = ~clk;

  reduce_window #(.WIDTH(8), .WINDOW(4), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy0), .in_data(in_data), .o(o0), .out_valid(ov0),
    .busy(busy0), .hit_cnt(hit0));

  reduce_window #(.WIDTH(8), .WINDOW(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy1), .in_data(in_data), .o(o1), .out_valid(ov1),
    .busy(busy1), .hit_cnt(hit1));

  reduce_window #(.WIDTH(8), .WINDOW(1), .CNT_W(8)) u_w1 (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy2), .in_data(in_data), .o(o2), .out_valid(ov2),
    .busy(busy2), .hit_cnt(hit2));

  typedef struct {
    logic [1:0]  m;
    logic [31:0] d;
    logic        eo;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives four samples (first byte = d[31:24]); leaves the bench at the
  // negedge of the DONE cycle with in_valid low.
  task automatic run_window(input logic [1:0] m0, input logic [1:0] m1,
                            input logic [31:0] d, input int gaps);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gaps; g++) begin
          @(negedge clk);
          in_valid = 1'b0;
          chk("gap_busy", 32'(busy0), 32'd1);
        end
      end
      @(negedge clk);
      if (i == 3) chk("early_valid", 32'(ov0), 32'd0);
      mode     = (i == 0) ? m0 : m1;
      in_valid = 1'b1;
      in_data  = d[31-8*i -: 8];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{m: 2'b00, d: 32'h00_00_10_00, eo: 1'b1};
    vecs[1] = '{m: 2'b01, d: 32'hFF_FF_FE_FF, eo: 1'b0};
    vecs[2] = '{m: 2'b10, d: 32'h01_03_07_00, eo: 1'b0};
    vecs[3] = '{m: 2'b11, d: 32'h00_00_00_00, eo: 1'b1};
    vecs[4] = '{m: 2'b10, d: 32'h01_00_00_00, eo: 1'b1};
    vecs[5] = '{m: 2'b01, d: 32'hFF_FF_FF_FF, eo: 1'b1};
    vecs[6] = '{m: 2'b11, d: 32'h00_00_80_00, eo: 1'b0};

    #12;
    chk("rst_o", 32'(o0), 32'd0);
    chk("rst_valid", 32'(ov0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_hit", 32'(hit0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(rdy0), 32'd1);

    for (int v = 0; v < 7; v++) begin
      run_window(vecs[v].m, vecs[v].m, vecs[v].d, 0);
      if (vecs[v].eo) exp_hit++;
      chk($sformatf("v%0d_valid", v), 32'(ov0), 32'd1);
      chk($sformatf("v%0d_o", v), 32'(o0), 32'(vecs[v].eo));
      chk($sformatf("v%0d_ready", v), 32'(rdy0), 32'd0);
      chk($sformatf("v%0d_hit", v), 32'(hit0), 32'(exp_hit));
      @(negedge clk);
      chk($sformatf("v%0d_pulse_end", v), 32'(ov0), 32'd0);
      chk($sformatf("v%0d_o_hold", v), 32'(o0), 32'(vecs[v].eo));
    end

    // OR latched at window start must survive a mode change and idle gaps.
    run_window(2'b00, 2'b01, 32'h01_00_00_00, 3);
    exp_hit++;
    chk("latch_valid", 32'(ov0), 32'd1);
    chk("latch_o", 32'(o0), 32'd1);
    chk("latch_hit", 32'(hit0), 32'(exp_hit));
    @(negedge clk);

    // Reset in the middle of a window.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mode = 2'b00; in_valid = 1'b1; in_data = 8'h01;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_o", 32'(o0), 32'd0);
    chk("mid_rst_valid", 32'(ov0), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    chk("mid_rst_hit", 32'(hit0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_hit = 0;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy0), 32'd1);

    // Saturation on the 2-bit counter.
    for (int w = 0; w < 5; w++) begin
      run_window(2'b00, 2'b00, 32'h01_00_00_00, 0);
      exp_hit++;
      chk($sformatf("sat%0d_hit", w), 32'(hit1), 32'((w < 3) ? w + 1 : 3));
      chk($sformatf("sat%0d_hit_wide", w), 32'(hit0), 32'(exp_hit));
      @(negedge clk);
    end

    // clr mid-window with a sample offered in the same cycle.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      mode = 2'b00; in_valid = 1'b1; in_data = 8'h00;
    end
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_hit", 32'(hit0), 32'd0);
    chk("clr_hit_sat", 32'(hit1), 32'd0);
    chk("clr_o", 32'(o0), 32'd0);
    chk("clr_busy", 32'(busy0), 32'd0);
    chk("clr_ready", 32'(rdy0), 32'd1);
    run_window(2'b00, 2'b00, 32'h00_00_00_00, 0);
    chk("clr_fresh_valid", 32'(ov0), 32'd1);
    chk("clr_fresh_o", 32'(o0), 32'd0);
    chk("clr_fresh_hit", 32'(hit0), 32'd0);
    @(negedge clk);
    @(negedge clk);

    // WINDOW=1: accept and DONE alternate.
    mode = 2'b01; in_valid = 1'b1; in_data = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("w1_ready%0d", k), 32'(rdy2), 32'((k % 2) == 0));
      chk($sformatf("w1_valid%0d", k), 32'(ov2), 32'((k % 2) == 1));
      if (k % 2 == 1) chk($sformatf("w1_o%0d", k), 32'(o2), 32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reduce_window.md
Name: reduce_window

Overview:
- Parametrised, registered successor to the fixed 8-input OR gate.
- Reduces a WIDTH-bit input vector with a selectable operator (OR/AND/XOR/NOR), then combines WINDOW consecutive accepted samples into one registered result.
- Uses a valid/ready handshake and keeps a saturating hit counter.
- Sits between raw flag sources (status lines, comparator outputs) and the downstream event logic.

Parameters:
- WIDTH, 8: number of input bits reduced per sample; must be ≥ 1.
- WINDOW, 4: number of accepted samples per result; must be ≥ 1.
- CNT_W, 8: width of the hit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear; aborts the current window and zeroes hit_cnt.
- mode  input  2  operator: 00 OR, 01 AND, 10 XOR, 11 NOR.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a sample.
- in_data  input  WIDTH  sample vector.
- o  output  1  window result.
- out_valid  output  1  one-cycle pulse; o is valid.
- busy  output  1  window in progress (state ACC).
- hit_cnt  output  CNT_W  count of windows whose result was 1; saturating.

Behaviour:
- Reset (async, rst=1): state IDLE; o=0, out_valid=0, busy=0, hit_cnt=0, sample counter=0, accumulator=0, latched mode=00. in_ready=1 once reset is released.
- Accept: a sample is accepted when in_valid && in_ready at a rising edge.
- in_ready: 1 in IDLE and ACC, 0 in DONE. Combinational from state only; no dependence on in_valid.
- Per-sample value r:
  - mode 00: OR of in_data.
  - mode 01: AND of in_data.
  - mode 10: XOR of in_data.
  - mode 11: OR of in_data (inversion applied at window end).
- Window combine, using the latched mode:
  - OR and NOR: acc |= r.
  - AND: acc &= r.
  - XOR: acc ^= r.
  - At window end: o = acc, or ~acc for NOR.
- Mode latch: mode is sampled on the first accepted sample of a window (the IDLE accept). Changes to mode during ACC are ignored until the next window.
- States:
  - IDLE:
    - On accept: acc=r, count=1, latch mode.
    - If WINDOW=1, go to DONE; otherwise go to ACC.
    - No accept: stay in IDLE.
  - ACC (busy=1):
    - On accept: update acc, increment count.
    - When count reaches WINDOW: go to DONE, registering o and the hit_cnt update.
    - Cycles with no accept hold all state; there is no timeout.
  - DONE: out_valid=1 for exactly this one cycle, o valid, in_ready=0. Unconditionally returns to IDLE next cycle.
- Latency: out_valid is asserted in the cycle immediately after the edge that accepts sample number WINDOW.
- Output hold: o holds its value until the next DONE, clr or reset.
- hit_cnt: increments by 1 on entry to DONE when the result is 1. Holds at 2^CNT_W−1; never wraps.
- clr (synchronous) takes priority over every state transition: next state IDLE, acc=0, count=0, o=0, hit_cnt=0, out_valid=0.
  - A sample presented in the same cycle as clr is discarded.
  - clr asserted while in DONE: the out_valid pulse in that cycle still occurs. The next cycle is IDLE with o=0.
- Reset mid-window: everything returns immediately to reset values; the partial window is lost.
- Sample counter width is clog2(WINDOW+1). All arithmetic is unsigned.

Test Plan:
- Reset/idle: assert rst mid-ACC after 2 samples → o=0, out_valid=0, busy=0, hit_cnt=0 immediately. After release, in_ready=1.
- OR window: WIDTH=8, WINDOW=4, mode=00, samples 00,00,10,00 back-to-back → out_valid pulses one cycle after the 4th accept, o=1, hit_cnt=1. in_ready=0 during the DONE cycle.
- AND/XOR/NOR:
  - mode=01 with FF,FF,FE,FF → o=0, hit_cnt unchanged.
  - mode=10 with 01,03,07,00 → per-sample r=1,0,1,0, o=0.
  - mode=11 with 00 ×4 → o=1, hit_cnt+1.
- Mode latch and gaps: start a window with mode=00, switch mode to 01 after the first accept, insert 3 idle cycles between samples 01,00,00,00 → o=1 (OR still applied), busy held high through the gaps.
- clr and saturation:
  - CNT_W=2: run 5 windows with result 1 → hit_cnt reads 1,2,3,3,3.
  - Then assert clr mid-window with in_valid=1 → hit_cnt=0, o=0, state IDLE, that sample not counted.
- WINDOW=1 corner: every accepted sample of FF with mode=01 → alternating cycles: accept, DONE (o=1). in_ready pattern 1,0,1,0.
